// File: rtl/conc_bus_responder.sv
// conc_bus_responder
//   Memory responder on the DUT side of the b14 processor bus. DUT reads are
//   answered from an internal word memory after a fixed latency. DUT writes
//   update that memory and are also logged into a trace FIFO that the bench
//   drains.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   addr, datao, rd, wr   DUT bus request (sampled every rising edge)
//   datai                 read data returned to the DUT (held between reads)
//   ld_valid/addr/data    preload write port; has priority over DUT writes
//   tr_valid/ready        trace FIFO handshake (pop on valid && ready)
//   tr_addr/data          trace FIFO head, zero while the FIFO is empty
//   tr_overflow           sticky: a trace push was dropped because the FIFO was full
//   err                   sticky: rd+wr together, or preload colliding with a DUT write
//   rd_count/wr_count     accepted reads/writes, saturating at 16'hFFFF
//
// READ_LAT must lie in 1..4.
module conc_bus_responder #(
    parameter int          AW       = 5,
    parameter int          READ_LAT = 1,
    parameter logic [30:0] OOR_DATA = 31'h0,
    parameter int          TR_AW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [19:0]   addr,
    input  logic [30:0]   datao,
    input  logic          rd,
    input  logic          wr,
    output logic [30:0]   datai,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [30:0]   ld_data,
    output logic          tr_valid,
    input  logic          tr_ready,
    output logic [19:0]   tr_addr,
    output logic [30:0]   tr_data,
    output logic          tr_overflow,
    output logic          err,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
);

    localparam int DEPTH    = 2 ** AW;
    localparam int TR_DEPTH = 2 ** TR_AW;

    typedef struct packed {
        logic [19:0] addr;
        logic [30:0] data;
    } tr_entry_t;

    // ------------------------------------------------------------------
    // Address decode and memory
    // ------------------------------------------------------------------
    logic          in_range;
    logic [AW-1:0] idx;
    logic [30:0]   rd_data;
    logic          dut_mem_wr;

    logic [30:0] mem_q [DEPTH];

    assign in_range = (addr[19:AW] == '0);
    assign idx      = addr[AW-1:0];

    // The read is taken from the memory as it stands before this edge, so
    // any write or preload in the same cycle leaves the read unaffected.
    assign rd_data  = in_range ? mem_q[idx] : OOR_DATA;

    // The preload port wins a memory-write collision. The DUT write is
    // still counted and traced.
    assign dut_mem_wr = wr && in_range && !ld_valid;

    // The memory contents are deliberately kept across reset.
    always_ff @(posedge clock) begin
        if (ld_valid) begin
            mem_q[ld_addr] <= ld_data;
        end else if (dut_mem_wr) begin
            mem_q[idx] <= datao;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // A read sampled at edge T lands in datai at edge T+READ_LAT-1. That
    // leaves READ_LAT-1 in-flight stages ahead of the datai register.
    // ------------------------------------------------------------------
    logic [30:0] datai_q;

    generate
        if (READ_LAT == 1) begin : g_lat1
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    datai_q <= '0;
                end else if (rd) begin
                    datai_q <= rd_data;
                end
            end
        end else begin : g_latn
            localparam int STAGES = READ_LAT - 1;
            logic [STAGES-1:0]       vld_pipe_q;
            logic [STAGES-1:0][30:0] dat_pipe_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vld_pipe_q <= '0;
                    dat_pipe_q <= '0;
                    datai_q    <= '0;
                end else begin
                    vld_pipe_q[0] <= rd;
                    dat_pipe_q[0] <= rd_data;
                    for (int k = 1; k < STAGES; k++) begin
                        vld_pipe_q[k] <= vld_pipe_q[k-1];
                        dat_pipe_q[k] <= dat_pipe_q[k-1];
                    end
                    if (vld_pipe_q[STAGES-1]) begin
                        datai_q <= dat_pipe_q[STAGES-1];
                    end
                end
            end
        end
    endgenerate

    assign datai = datai_q;

    // ------------------------------------------------------------------
    // Trace FIFO
    // Each pointer carries one extra wrap bit. Equal pointers mean empty.
    // Pointers that differ only in the wrap bit mean full.
    // ------------------------------------------------------------------
    logic [TR_AW:0] wptr_q, wptr_d;
    logic [TR_AW:0] rptr_q, rptr_d;
    logic           fifo_empty, fifo_full;
    logic           pop, push_ok, push_drop;
    tr_entry_t      head;

    tr_entry_t fifo_q [TR_DEPTH];

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[TR_AW] != rptr_q[TR_AW]) &&
                        (wptr_q[TR_AW-1:0] == rptr_q[TR_AW-1:0]);
    assign pop        = !fifo_empty && tr_ready;

    // When the FIFO is full and is popped in the same cycle, the push still
    // lands. The slot being freed is the one the new entry overwrites.
    assign push_ok    = wr && (!fifo_full || pop);
    assign push_drop  = wr && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_q[wptr_q[TR_AW-1:0]] <= '{addr: addr, data: datao};
        end
    end

    assign head     = fifo_q[rptr_q[TR_AW-1:0]];
    assign tr_valid = !fifo_empty;

    // The head is masked while the FIFO is empty, so uninitialised storage
    // never shows on the outputs.
    assign tr_addr  = fifo_empty ? '0 : head.addr;
    assign tr_data  = fifo_empty ? '0 : head.data;

    // ------------------------------------------------------------------
    // Pointers, counters and sticky flags
    // ------------------------------------------------------------------
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;
        ovf_d      = ovf_q;

        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push_drop) begin
            ovf_d = 1'b1;
        end

        if (rd && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (wr && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end

        // Two error cases: a read and a write on the bus together, or a
        // preload colliding with an in-range DUT write.
        if ((rd && wr) || (ld_valid && wr && in_range)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;
    assign err         = err_q;
    assign tr_overflow = ovf_q;

endmodule

// File: tb/tb_conc_bus_responder.sv
module tb_conc_bus_responder;

    localparam int          AW    = 5;
    localparam int          TR_AW = 3;
    localparam int          DEPTH = 32;
    localparam int          TRD   = 8;
    localparam logic [30:0] OOR   = 31'h5A5A5A5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [19:0]   addr = '0;
    logic [30:0]   datao = '0;
    logic          rd = 1'b0, wr = 1'b0;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [30:0]   ld_data = '0;
    logic          tr_ready = 1'b0;

    // Outputs of the READ_LAT=1 instance (suffix 1) and the READ_LAT=3 instance (suffix 3).
    logic [30:0] datai1, datai3, tr_data1, tr_data3;
    logic [19:0] tr_addr1, tr_addr3;
    logic        tr_valid1, tr_valid3, ovf1, ovf3, err1, err3;
    logic [15:0] rdc1, rdc3, wrc1, wrc3;

    conc_bus_responder #(.AW(AW), .READ_LAT(1), .OOR_DATA(OOR), .TR_AW(TR_AW)) dut1 (
        .clock(clock), .reset(reset), .addr(addr), .datao(datao), .rd(rd), .wr(wr),
        .datai(datai1), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .tr_valid(tr_valid1), .tr_ready(tr_ready), .tr_addr(tr_addr1), .tr_data(tr_data1),
        .tr_overflow(ovf1), .err(err1), .rd_count(rdc1), .wr_count(wrc1));

    conc_bus_responder #(.AW(AW), .READ_LAT(3), .OOR_DATA(OOR), .TR_AW(TR_AW)) dut3 (
        .clock(clock), .reset(reset), .addr(addr), .datao(datao), .rd(rd), .wr(wr),
        .datai(datai3), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .tr_valid(tr_valid3), .tr_ready(tr_ready), .tr_addr(tr_addr3), .tr_data(tr_data3),
        .tr_overflow(ovf3), .err(err3), .rd_count(rdc3), .wr_count(wrc3));

    always #5 clock = ~clock;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a word array, pending read results tagged with the
    // cycle they are due, a queue for the trace FIFO, and plain integers.
    typedef struct {
        int          due;
        logic [30:0] val;
    } pend_t;

    logic [30:0] m_mem [DEPTH];
    pend_t       pq1[$], pq3[$];
    logic [50:0] m_fifo[$];
    logic [30:0] e_d1 = '0, e_d3 = '0;
    bit          m_ovf = 0, m_err = 0;
    int          m_rc = 0, m_wc = 0;
    int          cyc = 0;

    task automatic model_reset();
        pq1.delete(); pq3.delete(); m_fifo.delete();
        e_d1 = '0; e_d3 = '0; m_ovf = 0; m_err = 0; m_rc = 0; m_wc = 0;
    endtask

    task automatic compare_all();
        logic [19:0] ha;
        logic [30:0] hd;
        ha = '0; hd = '0;
        if (m_fifo.size() > 0) begin
            ha = m_fifo[0][50:31];
            hd = m_fifo[0][30:0];
        end
        chk("datai_l1", datai1, e_d1);
        chk("datai_l3", datai3, e_d3);
        chk("tr_valid", tr_valid1, m_fifo.size() > 0);
        chk("tr_addr", tr_addr1, ha);
        chk("tr_data", tr_data1, hd);
        chk("tr_overflow", ovf1, m_ovf);
        chk("err", err1, m_err);
        chk("rd_count", rdc1, m_rc);
        chk("wr_count", wrc1, m_wc);
        chk("tr_head_l3", {tr_valid3, tr_addr3, tr_data3}, {tr_valid1 ? 1'b1 : 1'b0, ha, hd});
        chk("flags_l3", {ovf3, err3, rdc3, wrc3}, {m_ovf, m_err, m_rc[15:0], m_wc[15:0]});
    endtask

    // One bus cycle: drive the inputs, update the model at the edge, then check.
    task automatic cycle(input bit i_rd, input bit i_wr, input logic [19:0] i_addr,
                         input logic [30:0] i_do, input bit i_ld, input logic [AW-1:0] i_la,
                         input logic [30:0] i_ldd, input bit i_rdy);
        bit          inr, pop;
        logic [30:0] rv;
        rd = i_rd; wr = i_wr; addr = i_addr; datao = i_do;
        ld_valid = i_ld; ld_addr = i_la; ld_data = i_ldd; tr_ready = i_rdy;
        inr = (i_addr >> AW) == 0;
        rv  = inr ? m_mem[i_addr[AW-1:0]] : OOR;
        pop = (m_fifo.size() > 0) && i_rdy;
        @(posedge clock);
        cyc++;
        if (i_rd) begin
            pq1.push_back('{cyc, rv});
            pq3.push_back('{cyc + 2, rv});
            if (m_rc < 65535) m_rc++;
        end
        while (pq1.size() > 0 && pq1[0].due == cyc) e_d1 = pq1.pop_front().val;
        while (pq3.size() > 0 && pq3[0].due == cyc) e_d3 = pq3.pop_front().val;
        if ((i_rd && i_wr) || (i_ld && i_wr && inr)) m_err = 1;
        if (i_ld) m_mem[i_la] = i_ldd;
        else if (i_wr && inr) m_mem[i_addr[AW-1:0]] = i_do;
        if (pop) void'(m_fifo.pop_front());
        if (i_wr) begin
            if (m_wc < 65535) m_wc++;
            if (m_fifo.size() == TRD) m_ovf = 1;
            else m_fifo.push_back({i_addr, i_do});
        end
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0, '0, rdy);
    endtask

    // Reset asserted between edges: the outputs must clear at once.
    task automatic mid_reset();
        rd = 0; wr = 0; ld_valid = 0;
        reset = 1'b1;
        #2;
        model_reset();
        compare_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        reset = 1'b0;

        // Preload the whole memory with known words.
        for (int i = 0; i < DEPTH; i++)
            cycle(0, 0, '0, '0, 1, AW'(i), 31'(32'h100 + 32'h111 * i), 0);
        cycle(0, 0, '0, '0, 1, 5'd3, 31'h1234567, 0);

        cycle(1, 0, 20'h3, '0, 0, '0, '0, 0);
        chk("t_preload_read", datai1, 31'h1234567);
        chk("t_rd_count1", rdc1, 16'd1);

        cycle(0, 1, 20'h5, 31'h7FFF0000, 0, '0, '0, 0);
        cycle(1, 0, 20'h5, '0, 0, '0, '0, 0);
        chk("t_raw_read", datai1, 31'h7FFF0000);
        chk("t_head", {tr_addr1, tr_data1}, {20'h5, 31'h7FFF0000});
        chk("t_wr_count1", wrc1, 16'd1);

        cycle(1, 0, 20'h80, '0, 0, '0, '0, 0);
        chk("t_oor_read", datai1, OOR);

        cycle(0, 1, 20'h80, 31'h1111, 0, '0, '0, 0);
        cycle(1, 0, 20'h0, '0, 0, '0, '0, 0);
        chk("t_oor_write_dropped", datai1, 31'h100);

        cycle(0, 0, '0, '0, 1, 5'd2, 31'hA, 0);
        cycle(1, 1, 20'h2, 31'hB, 0, '0, '0, 0);
        chk("t_rdwr_old", datai1, 31'hA);
        chk("t_rdwr_err", err1, 1'b1);
        cycle(1, 0, 20'h2, '0, 0, '0, '0, 0);
        chk("t_rdwr_new", datai1, 31'hB);

        // Nine pushes into an empty FIFO of depth 8 with no pops, then drain in order.
        idle(10, 1);
        for (int i = 0; i < 9; i++) cycle(0, 1, 20'(20'h100 + i), 31'(32'hC00 + i), 0, '0, '0, 0);
        chk("t_overflow_set", ovf1, 1'b1);
        idle(9, 1);
        chk("t_drained", tr_valid1, 1'b0);

        // A full FIFO that is pushed and popped in the same cycle does not overflow.
        mid_reset();
        for (int i = 0; i < 8; i++) cycle(0, 1, 20'(20'h200 + i), 31'(32'hD00 + i), 0, '0, '0, 0);
        cycle(0, 1, 20'h2FF, 31'hEEE, 0, '0, '0, 1);
        chk("t_full_pushpop_no_ovf", ovf1, 1'b0);
        idle(9, 1);

        // Reads on three consecutive edges give three consecutive results.
        cycle(1, 0, 20'h3, '0, 0, '0, '0, 0);
        cycle(1, 0, 20'h5, '0, 0, '0, '0, 0);
        cycle(1, 0, 20'h2, '0, 0, '0, '0, 0);
        chk("t_lat3_first", datai3, 31'h1234567);
        cycle(0, 0, '0, '0, 0, '0, '0, 0);
        chk("t_lat3_second", datai3, 31'h7FFF0000);
        cycle(0, 0, '0, '0, 0, '0, '0, 0);
        chk("t_lat3_third", datai3, 31'hB);

        // A reset mid-pipeline discards the in-flight reads. Memory survives it.
        cycle(1, 0, 20'h5, '0, 0, '0, '0, 0);
        cycle(1, 0, 20'h2, '0, 0, '0, '0, 0);
        mid_reset();
        chk("t_rst_datai3", datai3, 31'h0);
        chk("t_rst_rdcount", rdc1, 16'd0);
        idle(3, 0);
        chk("t_rst_no_late", datai3, 31'h0);
        cycle(1, 0, 20'h3, '0, 0, '0, '0, 0);
        chk("t_mem_kept", datai1, 31'h1234567);

        // Random traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            logic [19:0] a;
            a = ($urandom_range(7) == 0) ? 20'($urandom) : 20'($urandom_range(DEPTH - 1));
            if ($urandom_range(150) == 0) mid_reset();
            cycle($urandom_range(1), $urandom_range(2) == 0, a, 31'($urandom),
                  $urandom_range(5) == 0, AW'($urandom), 31'($urandom), $urandom_range(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conc_bus_responder.md
Name: conc_bus_responder

Overview:
- Synthesizable memory responder that sits on the DUT side of the b14 processor bus in the concolic harness.
- Answers DUT `rd` cycles by driving `datai` from an internal word memory after a fixed latency, and performs DUT `wr` cycles into that memory.
- Logs every DUT write into a trace FIFO that the bench drains.
- Replaces the stimulus ROM when the DUT must see coherent read-after-write data.

Parameters:
- AW, 5, memory address bits; DEPTH = 2**AW words of 31 bits.
- READ_LAT, 1, cycles from a sampled `rd` to `datai` update; legal range 1..4.
- OOR_DATA, 31'h0, value returned for reads whose addr[19:AW] is nonzero.
- TR_AW, 3, trace FIFO address bits; FIFO depth = 2**TR_AW.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- addr  in  20  DUT bus address
- datao  in  31  DUT write data
- rd  in  1  DUT read strobe, sampled each rising edge
- wr  in  1  DUT write strobe, sampled each rising edge
- datai  out  31  read data to the DUT
- ld_valid  in  1  preload write enable
- ld_addr  in  AW  preload address
- ld_data  in  31  preload data
- tr_valid  out  1  trace FIFO not empty
- tr_ready  in  1  bench pops trace head
- tr_addr  out  20  trace head address
- tr_data  out  31  trace head data
- tr_overflow  out  1  sticky: a trace push was dropped
- err  out  1  sticky: protocol error
- rd_count  out  16  accepted reads, saturating
- wr_count  out  16  accepted writes, saturating

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
- Reset values: datai=0, tr_valid=0, tr_addr=0, tr_data=0, tr_overflow=0, err=0, rd_count=0, wr_count=0.
- Reset also clears the read pipeline and the FIFO pointers.
- Memory contents are NOT affected by reset.
- Reset mid-read: the in-flight read is discarded and datai stays 0.
- In range: addr[19:AW]==0; index = addr[AW-1:0].
- Read:
  - rd=1 at edge T is accepted; rd_count increments.
  - Data is captured at T: mem[index] if in range, else OOR_DATA.
  - datai takes that value at edge T+READ_LAT-1 (READ_LAT=1 means datai is registered at T itself and visible the cycle after).
  - datai holds its last value when no read completes.
  - Back-to-back reads are fully pipelined, one result per cycle.
- Write:
  - wr=1 at edge T is accepted; wr_count increments.
  - If in range, mem[index] <= datao.
  - Out-of-range writes are dropped from memory but still counted and traced.
- rd=1 and wr=1 in the same cycle:
  - err set.
  - Read returns pre-write data (read-before-write).
  - Write performed.
- ld_valid=1: mem[ld_addr] <= ld_data.
- ld_valid and an accepted in-range DUT write in the same cycle: ld wins, DUT write dropped from memory (still counted and traced), err set.
- A read of the same location in the same cycle as a preload returns the old data.
- Trace FIFO:
  - Every accepted wr pushes {addr, datao}.
  - tr_valid = !empty; tr_addr/tr_data show the head combinationally from registered storage.
  - Pop when tr_valid && tr_ready.
  - Push when full and no pop: entry dropped, tr_overflow set, FIFO unchanged.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Push when empty: tr_valid=1 the next cycle.
  - Pointers wrap modulo depth, with an extra bit for full/empty.
- Counters saturate at 16'hFFFF and do not wrap.
- err and tr_overflow clear only on reset.

Test Plan:
- Preload mem[3]=31'h1234567, then rd with addr=20'h3 (READ_LAT=1) -> datai=31'h1234567 one cycle later; rd_count=1.
- wr addr=20'h5, datao=31'h7FFF0000, next cycle rd addr=20'h5 -> datai=31'h7FFF0000; FIFO head {20'h5, 31'h7FFF0000}; wr_count=1.
- rd addr=20'h80 (out of range, AW=5) -> datai=OOR_DATA.
- wr addr=20'h80 -> memory unchanged (read back shows old value); trace entry present.
- rd+wr same cycle, addr=20'h2, old mem[2]=31'hA, datao=31'hB -> datai=31'hA, then a later read returns 31'hB; err=1.
- 9 writes with tr_ready=0 (depth 8) -> tr_overflow=1 and 8 entries drain in order.
- Separately, full FIFO with simultaneous push and pop -> tr_overflow stays 0.
- READ_LAT=3, reads issued at 3 consecutive edges -> 3 results on consecutive cycles.
- Assert reset mid-pipeline -> datai=0 immediately, counters 0; mem[3] still reads 31'h1234567 after reset.
